// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   ADDR_W            - width of the PC / Read_Address bus
//   INSTR_W           - width of an instruction word
//   HALT_WORD_DEFAULT - default encoding that stops fetching
//   state_e           - fetch FSM states
package instr_fetch_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 8;

  localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 8'hFF;

  typedef enum logic {
    StFetch,
    StHalted
  } state_e;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter for the fetch stage (the pc_reg block).
// Holds the PC, advances it by one modulo MEM_DEPTH, and loads a redirect
// address reduced modulo MEM_DEPTH. A load takes priority over an advance.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset, PC returns to 0
//   advance    - step PC to (PC+1) mod MEM_DEPTH
//   load       - load PC from load_addr (wrapped)
//   load_addr  - redirect address
//   pc         - current PC
module instr_fetch_pc_reg
  import instr_fetch_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MEM_DEPTH - 1);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] load_wrapped;

  // Explicit compare keeps the wrap correct for non-power-of-two depths.
  assign pc_inc       = (pc_q == LastAddr) ? '0 : pc_q + ADDR_W'(1);
  assign load_wrapped = ADDR_W'(32'(load_addr) % MEM_DEPTH);

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_wrapped;
    end else if (advance) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the PC to instruction memory, captures the
// returned word into a single output slot with a valid/ready handshake, and
// stops fetching after capturing HALT_WORD.
// Optional feature: define FETCH_BRANCH_EN to honour branch_en/branch_target
// (redirect + flush, also leaves HALTED). Without it those inputs are ignored
// and HALTED is left only by reset.
// Ports:
//   clk           - clock, rising edge
//   reset         - asynchronous active-high reset
//   Read_Address  - current PC to instruction memory
//   instruction   - memory word at Read_Address (combinational)
//   stall         - inhibits new fetches while high
//   branch_en     - single-cycle redirect request
//   branch_target - redirect address
//   out_instr     - fetched instruction
//   out_pc        - address of out_instr
//   out_valid     - output slot holds a valid instruction
//   out_ready     - decode accepts the instruction this cycle
//   halted        - fetch is stopped
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned        MEM_DEPTH = 32,
  parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  Read_Address,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               stall,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               halted
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
  logic               out_valid_q, out_valid_d;

  logic [ADDR_W-1:0]  pc;
  logic               pc_advance;
  logic               redirect;
  logic               slot_free;
  logic               fetch_ok;

`ifdef FETCH_BRANCH_EN
  assign redirect = branch_en;
`else
  assign redirect = 1'b0;
  logic unused_branch_en;
  assign unused_branch_en = branch_en;
`endif

  instr_fetch_pc_reg #(
    .MEM_DEPTH (MEM_DEPTH)
  ) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .advance   (pc_advance),
    .load      (redirect),
    .load_addr (branch_target),
    .pc        (pc)
  );

  // The slot can take a new word when empty or being drained this cycle.
  assign slot_free = !out_valid_q || out_ready;
  assign fetch_ok  = (state_q == StFetch) && !stall;

  always_comb begin
    state_d     = state_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_valid_d = out_valid_q;
    pc_advance  = 1'b0;

    if (redirect) begin
      // Redirect beats stall, hold and any capture on the same edge.
      out_valid_d = 1'b0;
      state_d     = StFetch;
    end else if (slot_free) begin
      if (fetch_ok) begin
        out_instr_d = instruction;
        out_pc_d    = pc;
        out_valid_d = 1'b1;
        pc_advance  = 1'b1;
        if (instruction == HALT_WORD) begin
          state_d = StHalted;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StFetch;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Read_Address = pc;
  assign out_instr    = out_instr_q;
  assign out_pc       = out_pc_q;
  assign out_valid    = out_valid_q;
  assign halted       = (state_q == StHalted);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// transaction-level model of the fetch slot.
module tb_instr_fetch;

  localparam int unsigned Depth = 32;
  localparam logic [7:0]  Halt  = 8'hFF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0;
  logic       branch_en = 1'b0;
  logic [7:0] branch_target = 8'd0;
  logic       out_ready = 1'b0;
  logic [7:0] instruction;
  logic [7:0] Read_Address;
  logic [7:0] out_instr;
  logic [7:0] out_pc;
  logic       out_valid;
  logic       halted;

  logic [7:0] mem [256];

  int n_vec = 0;
  int n_err = 0;

  // Model state: the PC, the single output slot, and the halt flag.
  int         m_pc = 0;
  int         m_opc = 0;
  bit         m_valid = 1'b0;
  bit         m_halted = 1'b0;
  logic [7:0] m_instr = 8'd0;

  assign instruction = mem[Read_Address];

  always #5 clk = ~clk;

  instr_fetch #(
    .MEM_DEPTH (Depth),
    .HALT_WORD (Halt)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Read_Address  (Read_Address),
    .instruction   (instruction),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .halted        (halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one output slot; a word enters when the slot drains or is
  // empty, fetching is allowed, and the machine is not halted.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc     = 0;
      m_opc    = 0;
      m_valid  = 1'b0;
      m_instr  = 8'd0;
      m_halted = 1'b0;
    end else begin
      bit free;
      free = !m_valid || out_ready;
`ifdef FETCH_BRANCH_EN
      if (branch_en) begin
        m_pc     = branch_target % Depth;
        m_valid  = 1'b0;
        m_halted = 1'b0;
      end else
`endif
      if (free) begin
        if (!m_halted && !stall) begin
          m_instr  = mem[m_pc];
          m_opc    = m_pc;
          m_valid  = 1'b1;
          m_halted = (mem[m_pc] == Halt);
          m_pc     = (m_pc + 1) % Depth;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("read_address", 32'(Read_Address), m_pc);
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("halted", 32'(halted), 32'(m_halted));
      if (m_valid) begin
        check("out_pc", 32'(out_pc), m_opc);
        check("out_instr", 32'(out_instr), 32'(m_instr));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    stall     = 1'b0;
    branch_en = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    out_ready = 1'b1;

    // Reset state and straight-line run with wrap.
    step();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_pc", 32'(out_pc), 0);
    check("rst_instr", 32'(out_instr), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_addr", 32'(Read_Address), 0);
    reset = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      step();
      check("seq_valid", 32'(out_valid), 1);
      check("seq_pc", 32'(out_pc), k % 32);
      check("seq_instr", 32'(out_instr), k % 32);
    end

    // Back-pressure for 3 cycles at out_pc=5.
    do_reset();
    for (int k = 0; k <= 5; k++) step();
    check("bp_pc0", 32'(out_pc), 5);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_pc", 32'(out_pc), 5);
      check("bp_instr", 32'(out_instr), 5);
      check("bp_addr", 32'(Read_Address), 6);
      check("bp_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    step();
    check("bp_next", 32'(out_pc), 6);

    // Stall for 2 cycles.
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check("stall_valid", 32'(out_valid), 0);
      check("stall_addr", 32'(Read_Address), 7);
    end
    stall = 1'b0;
    step();
    check("stall_next", 32'(out_pc), 7);
    check("stall_nvalid", 32'(out_valid), 1);

    // Halt word at address 4.
    mem[4] = Halt;
    do_reset();
    for (int k = 0; k <= 4; k++) step();
    check("halt_pc", 32'(out_pc), 4);
    check("halt_instr", 32'(out_instr), 32'(Halt));
    check("halt_flag", 32'(halted), 1);
    check("halt_addr", 32'(Read_Address), 5);
    for (int k = 0; k < 3; k++) begin
      step();
      check("halt_valid", 32'(out_valid), 0);
      check("halt_hold", 32'(halted), 1);
      check("halt_addr2", 32'(Read_Address), 5);
    end
    mem[4] = 8'd4;

    // Reset in the middle of a held handshake.
    do_reset();
    for (int k = 0; k < 3; k++) step();
    out_ready = 1'b0;
    step();
    check("mid_pc", 32'(out_pc), 2);
    check("mid_valid", 32'(out_valid), 1);
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_pc", 32'(out_pc), 0);
    check("arst_instr", 32'(out_instr), 0);
    check("arst_addr", 32'(Read_Address), 0);
    check("arst_halted", 32'(halted), 0);
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
    step();
    check("arst_first", 32'(out_pc), 0);
    check("arst_fvalid", 32'(out_valid), 1);

`ifdef FETCH_BRANCH_EN
    // Branch at out_pc=3 to 40 (wraps to 8), then escape HALTED.
    do_reset();
    for (int k = 0; k <= 3; k++) step();
    branch_en     = 1'b1;
    branch_target = 8'd40;
    step();
    branch_en = 1'b0;
    check("br_flush", 32'(out_valid), 0);
    check("br_addr", 32'(Read_Address), 8);
    step();
    check("br_pc", 32'(out_pc), 8);
    check("br_valid", 32'(out_valid), 1);
    mem[9] = Halt;
    step();
    check("br_halt", 32'(halted), 1);
    branch_en     = 1'b1;
    branch_target = 8'd2;
    step();
    branch_en = 1'b0;
    check("br_unhalt", 32'(halted), 0);
    check("br_uvalid", 32'(out_valid), 0);
    step();
    check("br_upc", 32'(out_pc), 2);
    mem[9] = 8'd9;
`endif

    // Randomized run.
    for (int c = 0; c < 3000; c++) begin
      if (c == 0 || $urandom_range(0, 199) == 0 || (m_halted && $urandom_range(0, 7) == 0)) begin
        reset = 1'b1;
        for (int i = 0; i < int'(Depth); i++) begin
          mem[i] = ($urandom_range(0, 11) == 0) ? Halt : 8'($urandom);
        end
        do_reset();
      end
      stall     = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
`ifdef FETCH_BRANCH_EN
      branch_en     = ($urandom_range(0, 15) == 0);
      branch_target = 8'($urandom);
`else
      branch_en     = ($urandom_range(0, 3) == 0);
      branch_target = 8'($urandom);
`endif
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
